// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: byte handshake, baud timing, shift strobes and txd framing.
// Optional parity bit is built when the macro UART_TX_PARITY_EN is defined (sense from PARITY_ODD).
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       sr_load,
   output logic [7:0] sr_data,
   output logic       sr_shift_en,
   input  logic       sr_serial,
   output logic       txd,
   output logic       busy,
   output logic       tx_done
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
         $error("uart_tx_ctrl: CLKS_PER_BIT must be in 2..65535");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
      end
      if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
         $error("uart_tx_ctrl: PARITY_ODD must be 0 or 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   state_e           state_q,    state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_idx_q,  bit_idx_d;
   logic             stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_PARITY_EN
   logic             parity_q,   parity_d;
`endif

   logic accept;
   logic bit_tick;
   logic last_stop;

   assign accept    = tx_valid & tx_ready;
   assign bit_tick  = (baud_cnt_q == CNT_LAST);
   assign last_stop = ({31'd0, stop_cnt_q} == 32'(STOP_BITS - 1));

   // The shift register sits outside this block; it loads on the accept edge.
   assign sr_load = accept;
   assign sr_data = tx_data;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   // NOTE: no memories here, so every flop is given an explicit reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every _d defaults to its _q first so no branch leaves a value
      // unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      if (state_q == S_IDLE) begin
         baud_cnt_d = '0;
      end else if (bit_tick) begin
         baud_cnt_d = '0;
      end else begin
         baud_cnt_d = baud_cnt_q + CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            stop_cnt_d = 1'b0;
            if (accept) begin
               state_d   = S_START;
               bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
               parity_d  = (^tx_data) ^ (PARITY_ODD != 0);
`endif
            end
         end
         S_START: begin
            if (bit_tick) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_tick) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_tick) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_tick) begin
               if (last_stop) state_d = S_IDLE;
               else           stop_cnt_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // txd depends only on registered state and sr_serial, never on tx_valid.
   always_comb begin
      tx_ready    = 1'b0;
      busy        = 1'b1;
      sr_shift_en = 1'b0;
      tx_done     = 1'b0;
      txd         = 1'b1;
      case (state_q)
         S_IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
         end
         S_START: begin
            txd = 1'b0;
         end
         S_DATA: begin
            txd         = sr_serial;
            sr_shift_en = bit_tick;
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            txd = parity_q;
         end
`endif
         S_STOP: begin
            tx_done = bit_tick & last_stop;
         end
         default: begin
            txd = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: driver pushes expected frames, a monitor decodes txd and compares.
// Includes a behavioural model of the external TX shift register.
module tb_uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
);

`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_BITS = 1 + 8 + PAR_BITS + STOP_BITS;
   localparam int FRAME_CYC  = FRAME_BITS * CLKS_PER_BIT;

   typedef struct packed {
      logic [7:0]  data;
      logic [15:0] levels;   // line level of each bit period, index 0 = start bit
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       sr_load;
   logic [7:0] sr_data;
   logic       sr_shift_en;
   logic       sr_serial;
   logic       txd;
   logic       busy;
   logic       tx_done;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_pushed = 0;
   int   frames_done = 0;
   bit   mon_active = 1'b0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   uart_tx_ctrl #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .STOP_BITS    (STOP_BITS),
      .PARITY_ODD   (PARITY_ODD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .sr_load     (sr_load),
      .sr_data     (sr_data),
      .sr_shift_en (sr_shift_en),
      .sr_serial   (sr_serial),
      .txd         (txd),
      .busy        (busy),
      .tx_done     (tx_done)
   );

   // External shift register: LSB first, fills with ones.
   logic [7:0] sr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           sr_q <= 8'hFF;
      else if (sr_load)     sr_q <= sr_data;
      else if (sr_shift_en) sr_q <= {1'b1, sr_q[7:1]};
   end
   assign sr_serial = sr_q[0];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a frame is a list of bit levels, each lasting CLKS_PER_BIT cycles.
   function automatic exp_t make_exp(input logic [7:0] d);
      exp_t e;
      e.data      = d;
      e.levels    = '1;
      e.levels[0] = 1'b0;
      for (int i = 0; i < 8; i++) e.levels[1+i] = d[i];
      if (PAR_BITS == 1) e.levels[9] = (^d) ^ (PARITY_ODD != 0);
      return e;
   endfunction

   // Present a byte, wait (bounded) for acceptance, record the expected frame.
   task automatic send(input logic [7:0] d, input bit hold);
      int t;
      tx_valid = 1'b1;
      tx_data  = d;
      t = 0;
      @(negedge clk);
      while (!tx_ready && t < 4 * FRAME_CYC) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", {31'd0, tx_ready}, 32'd1);
      if (tx_ready) begin
         exp_q.push_back(make_exp(d));
         n_pushed++;
      end
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t        e;
      bit          have;
      bit          aborted;
      logic [7:0]  act_data;
      logic [FRAME_CYC-1:0] wave;
      int low_cnt, exp_low, shifts, dones, done_pos, loads, bad_flags, wrong;
      forever begin
         if (rst_n === 1'b1 && sr_load === 1'b1) begin
            mon_active = 1'b1;
            act_data = sr_data;
            have = 1'b0; aborted = 1'b0;
            low_cnt = 0; shifts = 0; dones = 0; done_pos = -1; loads = 0; bad_flags = 0;
            wave = '1;
            for (int k = 0; k < FRAME_CYC; k++) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (k == 0) begin
                  check("scoreboard_entry", {31'd0, exp_q.size() > 0}, 32'd1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     have = 1'b1;
                  end
               end
               wave[k] = txd;
               if (!txd)       low_cnt++;
               if (sr_shift_en) shifts++;
               if (tx_done) begin
                  dones++;
                  done_pos = k;
               end
               if (sr_load)            loads++;
               if (!busy || tx_ready)  bad_flags++;
            end
            if (aborted) begin
               if (!have && exp_q.size() > 0) e = exp_q.pop_front();
            end else if (have) begin
               check("accept_data", {24'd0, act_data}, {24'd0, e.data});
               exp_low = 0;
               wrong   = 0;
               for (int i = 0; i < FRAME_BITS; i++) begin
                  check($sformatf("frame_bit%0d_mid", i),
                        {31'd0, wave[i*CLKS_PER_BIT + CLKS_PER_BIT/2]}, {31'd0, e.levels[i]});
                  if (!e.levels[i]) exp_low += CLKS_PER_BIT;
               end
               for (int k = 0; k < FRAME_CYC; k++)
                  if (wave[k] !== e.levels[k / CLKS_PER_BIT]) wrong++;
               check("wave_cycles_wrong", wrong, 0);
               check("low_cycles", low_cnt, exp_low);
               check("shift_pulses", shifts, 8);
               check("done_pulses", dones, 1);
               check("done_position", done_pos, FRAME_CYC - 1);
               check("load_while_busy", loads, 0);
               check("busy_ready_in_frame", bad_flags, 0);
               @(negedge clk);
               if (rst_n) begin
                  frames_done++;
                  check("gap_tx_ready", {31'd0, tx_ready}, 32'd1);
                  check("gap_busy", {31'd0, busy}, 32'd0);
                  check("gap_txd", {31'd0, txd}, 32'd1);
                  if (tx_valid) check("b2b_accept_first_idle", {31'd0, sr_load}, 32'd1);
               end
            end
            mon_active = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   end

   initial begin : main
      int t;
      bit hold;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_shift_en", {31'd0, sr_shift_en}, 32'd0);
      check("rst_tx_done", {31'd0, tx_done}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      send(8'hA5, 1'b0);

      // Back-to-back with tx_valid held across the boundary.
      send(8'h00, 1'b1);
      send(8'hFF, 1'b0);

      // tx_valid pulsed while the frame is in DATA must be ignored.
      send(8'h3C, 1'b0);
      repeat (CLKS_PER_BIT * 3) @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = 8'hEE;
      repeat (5) @(posedge clk);
      #1;
      check("busy_while_intruding", {31'd0, busy}, 32'd1);
      tx_valid = 1'b0;

      // Reset in the middle of data bit 4.
      send(8'hC3, 1'b0);
      repeat (CLKS_PER_BIT * 5 + CLKS_PER_BIT / 2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_txd", {31'd0, txd}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("midrst_shift_en", {31'd0, sr_shift_en}, 32'd0);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(8'h81, 1'b0);
      send(8'h07, 1'b0);

      for (int n = 0; n < 24; n++) begin
         hold = (n == 23) ? 1'b0 : 1'($urandom_range(0, 1));
         send(8'($urandom), hold);
         if (!hold) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
         end
      end

      t = 0;
      while ((exp_q.size() != 0 || mon_active) && t < 4 * FRAME_CYC) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check("drain_queue_empty", exp_q.size(), 0);
      check("frames_completed", frames_done, n_pushed - 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
